// File: rtl/configs_loader.sv
// configs_loader: write-side sequencer for the configuration-latch array.
// Accepts NUM_WORDS configuration words and, for each one, drives the shared
// latch data bus one cycle before, during and after a single one-hot enable
// strobe (LOAD -> SETUP -> STROBE -> HOLD, four cycles per word).
// Optional feature macro: CFG_LOADER_CHECKSUM_EN
//   defined   -> a trailing XOR checksum word is accepted in CHK and compared
//                against the XOR of all loaded words; mismatch raises io_err.
//   undefined -> no CHK state, no accumulator, io_err tied low.
module configs_loader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 13,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_data,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_err,
  output logic [2:0]           dbg_state
);

  // Handshake: a word transfers on a rising clk edge where io_in_valid and
  // io_in_ready are both high. io_in_ready depends only on the FSM state
  // (high in LOAD and CHK), never on io_in_valid; the source may hold valid
  // high for any number of cycles and must keep io_in_data stable while it does.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
`ifdef CFG_LOADER_CHECKSUM_EN
    S_CHK    = 3'd5,
`endif
    S_DONE   = 3'd6
  } state_t;

  localparam logic [NUM_WORDS-1:0] EN_ONE    = NUM_WORDS'(1);
  localparam logic [CNT_W-1:0]     LAST_WORD = CNT_W'(NUM_WORDS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       wc_q, wc_d;
  logic [WORD_W-1:0]      d_q, d_d;
  logic [NUM_WORDS-1:0]   en_q, en_d;
`ifdef CFG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]      acc_q, acc_d;
  logic                   err_q, err_d;
`endif

  // State and datapath registers; reset abandons any load and drops enables at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      d_q     <= '0;
      en_q    <= '0;
`ifdef CFG_LOADER_CHECKSUM_EN
      acc_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      d_q     <= d_d;
      en_q    <= en_d;
`ifdef CFG_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state, next-register values and the combinational handshake/status outputs.
  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    d_d         = d_q;
    en_d        = '0;
    io_in_ready = 1'b0;
    io_done     = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
    acc_d       = acc_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (io_start) begin
          state_d = S_LOAD;
          wc_d    = '0;
`ifdef CFG_LOADER_CHECKSUM_EN
          acc_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          state_d = S_SETUP;
          d_d     = io_in_data;
`ifdef CFG_LOADER_CHECKSUM_EN
          acc_d   = acc_q ^ io_in_data;
`endif
        end
      end
      S_SETUP: begin
        // Data bus has been stable for a full cycle; raise this word's strobe next.
        state_d = S_STROBE;
        en_d    = EN_ONE << wc_q;
      end
      S_STROBE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (wc_q == LAST_WORD) begin
`ifdef CFG_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          wc_d    = wc_q + 1'b1;
          state_d = S_LOAD;
        end
      end
`ifdef CFG_LOADER_CHECKSUM_EN
      S_CHK: begin
        // Checksum word is consumed here but never driven onto the latch bus.
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          err_d   = (io_in_data != acc_q);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        io_done = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign io_d_out      = d_q;
  assign io_configs_en = en_q;
  assign io_busy       = (state_q != S_IDLE);
  assign dbg_state     = state_q;
`ifdef CFG_LOADER_CHECKSUM_EN
  assign io_err        = err_q;
`else
  assign io_err        = 1'b0;
`endif

endmodule

// File: tb/tb_configs_loader.sv
// Bench for configs_loader: drives full and partial loads with random words
// and stalls; a negedge monitor logs every strobe as a latch-bank capture and
// tracks bus stability around strobes, and each scenario task checks the
// captured banks against the words it sent.
module tb_configs_loader;
  localparam int WW = 32;
  localparam int NW = 13;
  localparam int CW = 4;
`ifdef CFG_LOADER_CHECKSUM_EN
  localparam int LOAD_LAT = NW * 4 + 1;
`else
  localparam int LOAD_LAT = NW * 4;
`endif
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          in_ready;
  logic [WW-1:0] d_out;
  logic [NW-1:0] configs_en;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  configs_loader dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (start),
    .io_in_valid   (in_valid),
    .io_in_ready   (in_ready),
    .io_in_data    (in_data),
    .io_d_out      (d_out),
    .io_configs_en (configs_en),
    .io_busy       (busy),
    .io_done       (done),
    .io_err        (err),
    .dbg_state     (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [WW-1:0] words[NW];
  logic [WW-1:0] exp_q[$];
  logic          cs_flip = 1'b0;
  int            tmo_cnt = 0;

  // Monitor state
  int            cyc = 0;
  logic [WW-1:0] prev_d = '0;
  logic [NW-1:0] prev_en = '0;
  logic          prev_busy = 1'b0;
  int            stab_viol = 0;
  int            hot_viol = 0;
  logic [CW-1:0] obs_idx_q[$];
  logic [WW-1:0] obs_dat_q[$];
  int            load_cyc = 0;
  int            done_cyc = 0;
  int            done_cnt = 0;
  logic          err_at_done = 1'b0;

  // Monitor: every strobe is a latch capture; the bus must be stable around it.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      prev_d    = d_out;
      prev_en   = '0;
      prev_busy = 1'b0;
    end else begin
      if ($countones(configs_en) > 1) hot_viol++;
      if (configs_en != '0) begin
        if (d_out !== prev_d) stab_viol++;
        if (prev_en != '0) stab_viol++;
        for (int k = 0; k < NW; k++) begin
          if (configs_en[k]) begin
            obs_idx_q.push_back(CW'(k));
            obs_dat_q.push_back(d_out);
          end
        end
      end
      if (prev_en != '0 && d_out !== prev_d) stab_viol++;
      if (busy && !prev_busy) load_cyc = cyc;
      if (done) begin
        done_cyc    = cyc;
        done_cnt++;
        err_at_done = err;
      end
      prev_d    = d_out;
      prev_en   = configs_en;
      prev_busy = busy;
    end
  end

  task automatic clear_mon();
    obs_idx_q.delete();
    obs_dat_q.delete();
    exp_q.delete();
    stab_viol = 0;
    hot_viol  = 0;
    done_cnt  = 0;
    load_cyc  = 0;
    done_cyc  = 0;
    tmo_cnt   = 0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < NW; k++) words[k] = $urandom;
  endtask

  // Present one word, wait (bounded) for the handshake edge, then drop valid.
  task automatic send_word(input logic [WW-1:0] w, input int stall);
    int t;
    in_valid = 1'b0;
    repeat (stall) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) tmo_cnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Pulse start, then send n_send words; a full load also waits for done.
  task automatic run_load(input int max_stall, input int stall_word, input int stall_len,
                          input int start_word, input int n_send);
    int s;
    int t;
`ifdef CFG_LOADER_CHECKSUM_EN
    logic [WW-1:0] x;
    x = '0;
`endif
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < n_send; k++) begin
      s = (k == stall_word) ? stall_len : int'($urandom_range(0, max_stall));
      if (k == start_word) start = 1'b1;
      exp_q.push_back(words[k]);
`ifdef CFG_LOADER_CHECKSUM_EN
      x = x ^ words[k];
`endif
      send_word(words[k], s);
      start = 1'b0;
    end
    if (n_send == NW) begin
`ifdef CFG_LOADER_CHECKSUM_EN
      send_word(x ^ {{(WW-1){1'b0}}, cs_flip}, 0);
`endif
      t = 0;
      while (done_cnt == 0 && t < 400) begin
        @(negedge clk); #1;
        t++;
      end
      if (done_cnt == 0) tmo_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_d_out: got %h want 0", d_out); end
    checks++; if (configs_en !== '0) begin errors++; $display("FAIL reset_en: got %h want 0", configs_en); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy %b done %b err %b want 000", busy, done, err);
    end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] e;
    clear_mon();
    for (int k = 0; k < NW; k++) words[k] = 32'h1000_0000 + WW'(k);
    run_load(0, -1, 0, -1, NW);
    checks++; if (tmo_cnt !== 0) begin errors++; $display("FAIL b2b_timeout: got %0d timeouts want 0", tmo_cnt); end
    checks++; if (obs_idx_q.size() !== NW) begin errors++; $display("FAIL b2b_count: got %0d strobes want %0d", obs_idx_q.size(), NW); end
    for (int k = 0; k < NW; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (k >= obs_idx_q.size() || obs_idx_q[k] !== CW'(k) || obs_dat_q[k] !== e) begin
        errors++;
        $display("FAIL b2b_bank[%0d]: got bank/data %0d/%h want %0d/%h", k,
                 (k < obs_idx_q.size()) ? obs_idx_q[k] : 'x, (k < obs_dat_q.size()) ? obs_dat_q[k] : 'x, k, e);
      end
    end
    checks++; if (stab_viol !== 0 || hot_viol !== 0) begin
      errors++; $display("FAIL b2b_stability: got %0d/%0d violations want 0/0", stab_viol, hot_viol);
    end
    checks++; if (done_cyc - load_cyc !== LOAD_LAT) begin
      errors++; $display("FAIL b2b_latency: got %0d cycles want %0d", done_cyc - load_cyc, LOAD_LAT);
    end
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", err_at_done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_after_done: busy %b done %b want 00", busy, done); end
    checks++; if (d_out !== words[NW-1]) begin errors++; $display("FAIL b2b_idle_hold: got %h want %h", d_out, words[NW-1]); end
  endtask

  task automatic test_stall();
    fill_random();
    clear_mon();
    fork
      run_load(0, 5, 13, -1, NW);
      begin
        int t;
        int bad_rdy;
        int bad_en;
        int bad_d;
        t = 0; bad_rdy = 0; bad_en = 0; bad_d = 0;
        while (obs_idx_q.size() < 5 && t < 300) begin
          @(negedge clk); #1;
          t++;
        end
        checks++; if (t >= 300) begin errors++; $display("FAIL stall_reach_word4: got timeout want strobe of word 4"); end
        @(negedge clk);
        repeat (10) begin
          @(negedge clk);
          if (in_ready !== 1'b1) bad_rdy++;
          if (configs_en !== '0) bad_en++;
          if (d_out !== words[4]) bad_d++;
        end
        checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL stall_ready: got %0d low cycles want 0", bad_rdy); end
        checks++; if (bad_en !== 0) begin errors++; $display("FAIL stall_en: got %0d strobe cycles want 0", bad_en); end
        checks++; if (bad_d !== 0) begin errors++; $display("FAIL stall_d_out: got %0d changed cycles want 0", bad_d); end
      end
    join
    checks++; if (tmo_cnt !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL stall_done: got timeouts %0d dones %0d want 0 1", tmo_cnt, done_cnt);
    end
    checks++; if (obs_idx_q.size() !== NW) begin errors++; $display("FAIL stall_count: got %0d want %0d", obs_idx_q.size(), NW); end
    for (int k = 0; k < NW && k < obs_idx_q.size(); k++) begin
      checks++;
      if (obs_idx_q[k] !== CW'(k) || obs_dat_q[k] !== words[k]) begin
        errors++; $display("FAIL stall_bank[%0d]: got %0d/%h want %0d/%h", k, obs_idx_q[k], obs_dat_q[k], k, words[k]);
      end
    end
    checks++; if (stab_viol !== 0 || hot_viol !== 0) begin
      errors++; $display("FAIL stall_stability: got %0d/%0d want 0/0", stab_viol, hot_viol);
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    clear_mon();
    run_load(0, -1, 0, 3, NW);
    checks++; if (tmo_cnt !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL restart_done: got timeouts %0d dones %0d want 0 1", tmo_cnt, done_cnt);
    end
    checks++; if (done_cyc - load_cyc !== LOAD_LAT) begin
      errors++; $display("FAIL restart_latency: got %0d want %0d", done_cyc - load_cyc, LOAD_LAT);
    end
    checks++; if (obs_idx_q.size() !== NW) begin errors++; $display("FAIL restart_count: got %0d want %0d", obs_idx_q.size(), NW); end
    for (int k = 0; k < NW && k < obs_idx_q.size(); k++) begin
      checks++;
      if (obs_idx_q[k] !== CW'(k) || obs_dat_q[k] !== words[k]) begin
        errors++; $display("FAIL restart_bank[%0d]: got %0d/%h want %0d/%h", k, obs_idx_q[k], obs_dat_q[k], k, words[k]);
      end
    end
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL restart_idle: got state %0d busy %b want %0d 0", dbg_state, busy, ST_IDLE);
    end
  endtask

  task automatic test_random();
    logic [WW-1:0] bank[NW];
    for (int r = 0; r < 3; r++) begin
      fill_random();
      clear_mon();
      run_load(3, -1, 0, -1, NW);
      for (int k = 0; k < NW; k++) bank[k] = 'x;
      for (int i = 0; i < obs_idx_q.size(); i++) bank[obs_idx_q[i]] = obs_dat_q[i];
      checks++; if (tmo_cnt !== 0 || done_cnt !== 1) begin
        errors++; $display("FAIL rand%0d_done: got timeouts %0d dones %0d want 0 1", r, tmo_cnt, done_cnt);
      end
      checks++; if (obs_idx_q.size() !== NW) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs_idx_q.size(), NW); end
      for (int k = 0; k < NW; k++) begin
        checks++;
        if (bank[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_bank[%0d]: got %h want %h", r, k, bank[k], exp_q[k]); end
      end
      checks++; if (stab_viol !== 0 || hot_viol !== 0) begin
        errors++; $display("FAIL rand%0d_stability: got %0d/%0d want 0/0", r, stab_viol, hot_viol);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NW-1:0] b7;
    b7 = '0;
    b7[7] = 1'b1;
    fill_random();
    clear_mon();
    run_load(0, -1, 0, -1, 8);
    @(negedge clk);
    @(negedge clk);
    checks++; if (configs_en !== b7) begin errors++; $display("FAIL midrst_strobe7: got %h want %h", configs_en, b7); end
    #2 reset = 1'b0;
    #1;
    checks++; if (configs_en !== '0) begin errors++; $display("FAIL midrst_en_async: got %h want 0", configs_en); end
    checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: state %0d busy %b ready %b want 0 0 0", dbg_state, busy, in_ready);
    end
    checks++; if (obs_idx_q.size() !== 8 || obs_dat_q[7] !== words[7]) begin
      errors++; $display("FAIL midrst_captured: got %0d strobes want 8 with bank7 %h", obs_idx_q.size(), words[7]);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_abandoned: state %0d busy %b want 0 0", dbg_state, busy);
    end
    fill_random();
    clear_mon();
    run_load(1, -1, 0, -1, NW);
    checks++; if (tmo_cnt !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL midrst_reload_done: got timeouts %0d dones %0d want 0 1", tmo_cnt, done_cnt);
    end
    checks++; if (obs_idx_q.size() !== NW) begin errors++; $display("FAIL midrst_reload_count: got %0d want %0d", obs_idx_q.size(), NW); end
    for (int k = 0; k < NW && k < obs_idx_q.size(); k++) begin
      checks++;
      if (obs_idx_q[k] !== CW'(k) || obs_dat_q[k] !== words[k]) begin
        errors++; $display("FAIL midrst_reload_bank[%0d]: got %0d/%h want %0d/%h", k, obs_idx_q[k], obs_dat_q[k], k, words[k]);
      end
    end
  endtask

`ifdef CFG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    fill_random();
    clear_mon();
    cs_flip = 1'b0;
    run_load(0, -1, 0, -1, NW);
    checks++; if (done_cnt !== 1 || err_at_done !== 1'b0) begin
      errors++; $display("FAIL cs_good: got dones %0d err %b want 1 0", done_cnt, err_at_done);
    end
    @(negedge clk);
    clear_mon();
    cs_flip = 1'b1;
    run_load(2, -1, 0, -1, NW);
    checks++; if (done_cnt !== 1 || err_at_done !== 1'b1) begin
      errors++; $display("FAIL cs_bad: got dones %0d err %b want 1 1", done_cnt, err_at_done);
    end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cs_err_hold: got %b want 1", err); end
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || dbg_state !== ST_LOAD) begin
      errors++; $display("FAIL cs_err_clear: got err %b state %0d want 0 %0d", err, dbg_state, ST_LOAD);
    end
    cs_flip = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_start_ignored();
    test_random();
    test_reset_mid();
`ifdef CFG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/configs_loader.md
# configs_loader

Write-side sequencer for the configuration-latch array. It accepts a stream of 32-bit configuration words over a valid/ready handshake. It drives the shared latch data bus plus one one-hot enable strobe per word, so each transparent latch bank captures a stable value. Data is set up one cycle before the strobe and held one cycle after it. The block sits between the configuration shift/ingest path and the tile's latch banks, and produces the enable pattern those latches expect.

## Interface
- `WORD_W`, 32, width of one configuration word and of the latch data bus
- `NUM_WORDS`, 13, number of latch banks / words per full load (total config bits = `WORD_W*NUM_WORDS` = 416)
- `CNT_W`, 4, word-counter width; must satisfy `2**CNT_W >= NUM_WORDS`

- `clk` input 1 — single clock; all state on rising edge
- `reset` input 1 — asynchronous, active-low; asserting it (low) clears all state immediately
- `io_start` input 1 — one-cycle request to begin a full load; honoured only in IDLE
- `io_in_valid` input 1 — source has a word on `io_in_data`
- `io_in_ready` output 1 — block accepts a word this cycle
- `io_in_data` input `WORD_W` — configuration word
- `io_d_out` output `WORD_W` — latch data bus (registered)
- `io_configs_en` output `NUM_WORDS` — one-hot latch enables (registered); bit k selects bank k, i.e. bits `[32k+31:32k]`
- `io_busy` output 1 — high from the cycle after start is accepted until DONE completes
- `io_done` output 1 — one-cycle pulse at end of load
- `io_err` output 1 — checksum mismatch flag (see Configuration)

## Operation
- States: IDLE, LOAD, SETUP, STROBE, HOLD, CHK, DONE.
- IDLE:
  - `io_start=1` → LOAD; word counter `wc` ← 0; `io_err` ← 0.
  - `io_start` is ignored in every other state.
- LOAD:
  - `io_in_ready=1`.
  - On `io_in_valid & io_in_ready` → SETUP; `io_d_out` ← `io_in_data`.
  - With no valid, the block waits indefinitely with no timeout.
- SETUP: enables all 0, `io_d_out` stable → STROBE.
- STROBE: `io_configs_en` = one-hot bit `wc`, all other bits 0 → HOLD.
- HOLD: enables all 0, `io_d_out` unchanged.
  - If `wc == NUM_WORDS-1` → CHK when checksum is compiled in, else DONE.
  - Otherwise `wc` ← `wc+1` → LOAD.
- CHK: `io_in_ready=1`.
  - On handshake: `io_err` ← (`io_in_data` != XOR of all accepted words) → DONE.
  - No strobe is generated and `io_d_out` is not updated.
- DONE: `io_done=1` for one cycle → IDLE.
- `io_in_ready` is 0 in all states other than LOAD and CHK.
- `io_d_out` holds its last value in IDLE.
- At most one `io_configs_en` bit is ever high. It is never high in the same cycle `io_d_out` changes, nor in the cycle before or after.

## Timing
- Reset values:
  - `io_d_out=0`, `io_configs_en=0`, `io_in_ready=0`, `io_busy=0`, `io_done=0`, `io_err=0`.
  - State = IDLE, `wc=0`, XOR accumulator = 0.
- Reset asserted mid-load:
  - Enables drop to 0 asynchronously.
  - Latch banks keep whatever they captured.
  - The load is abandoned, not resumed.
- Start at edge T → LOAD in cycle T+1, `io_busy=1` from T+1.
- Handshake at edge N:
  - `io_d_out` valid in N+1 (SETUP).
  - Strobe high in N+2 (STROBE).
  - Strobe low in N+3 (HOLD).
  - `io_in_ready` high again in N+4.
- Minimum 4 cycles per word. With a back-to-back source, a full 13-word load without checksum takes 52 cycles from the first LOAD cycle to DONE.
- `io_busy` falls in the cycle after DONE.
- `io_done` and the final `io_err` are valid in the same DONE cycle. `io_err` holds until the next accepted start or reset.

## Configuration
- Macro `CFG_LOADER_CHECKSUM_EN`.
- Defined:
  - The load expects `NUM_WORDS+1` words; the extra one is a trailing checksum word.
  - The XOR accumulator is cleared on start and updated on every LOAD handshake.
  - CHK state present; `io_err` functional.
- Undefined:
  - No CHK state, no accumulator.
  - `io_err` tied to 0; HOLD of the last word → DONE.

## Test plan
- Reset low, then release; no stimulus → all outputs 0, `io_in_ready=0`, state IDLE.
- Start, source supplies words 0x1000_0000+k (k=0..12) back-to-back:
  - each `io_configs_en` bit k pulses exactly one cycle with `io_d_out=0x1000_0000+k` stable one cycle before and after;
  - `io_done` pulses 52 cycles after the first LOAD cycle (checksum off).
- Source stalls: `io_in_valid` low for 10 cycles before word 5 → `io_in_ready` stays high, enables stay 0, `io_d_out` holds word 4; sequence then resumes correctly.
- `io_start` pulsed again during word 3 → ignored; `wc` and the output sequence are unchanged.
- `reset` driven low during STROBE of word 7 → `io_configs_en` is 0 in the same cycle (before the next edge); after release the block is IDLE and a new full load completes correctly.
- `CFG_LOADER_CHECKSUM_EN` defined:
  - words 0..12 followed by their correct XOR → `io_done=1`, `io_err=0`;
  - repeat with checksum ^ 0x1 → `io_err=1` in the DONE cycle, cleared on the next start.
